// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline hazard controller placed beside the decode stage. It drives the
// stall/flush enables of the IF/ID, ID/EX and EX pipeline registers:
//   - load-use hazard between ID and EX: holds PC and IF/ID and injects
//     bubbles into ID/EX for LOAD_STALL_CYCLES cycles, matching data-memory
//     latency;
//   - multi-cycle MUL/DIV busy: freezes IF, ID and EX;
//   - taken branch/jump resolved in EX: squashes IF/ID and bubbles ID/EX.
// All outputs are combinational from the FSM state and the current inputs,
// so the first stall is raised in the same cycle the hazard is detected.
//
// Parameters
//   REG_ADDR_WIDTH     register address width
//   LOAD_STALL_CYCLES  bubbles per load-use hazard, legal range 1..7
//
// Ports
//   clk, rst                    core clock, asynchronous active-high reset
//   rs1/rs2_addr_ID_i           source registers of the instruction in ID
//   rs1/rs2_used_ID_i           ID instruction really reads rs1/rs2
//   rd_addr_EX_i                destination of the instruction in EX
//   valid_EX_i                  EX holds a real instruction (not a bubble)
//   is_load_EX_i                EX instruction writes back from memory
//   branch_taken_EX_i           branch/jump resolved taken in EX
//   mdu_busy_i                  multi-cycle MUL/DIV in EX not yet done
//   stall_IF_o                  hold PC / IF
//   stall_ID_o                  hold IF/ID register
//   stall_EX_o                  hold ID/EX and EX
//   bubble_EX_o                 load NOP into ID/EX
//   flush_ID_o                  squash IF/ID contents
//   busy_o                      FSM not in IDLE
//
// Optional feature (macro HAZARD_PERF_CNT_EN)
//   ld_stall_cnt_o              saturating count of load-hazard bubble cycles
//   flush_cnt_o                 saturating count of flush cycles
// -----------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int unsigned REG_ADDR_WIDTH    = 5,
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_ID_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_ID_i,
    input  logic                      rs1_used_ID_i,
    input  logic                      rs2_used_ID_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_EX_i,
    input  logic                      valid_EX_i,
    input  logic                      is_load_EX_i,
    input  logic                      branch_taken_EX_i,
    input  logic                      mdu_busy_i,
    output logic                      stall_IF_o,
    output logic                      stall_ID_o,
    output logic                      stall_EX_o,
    output logic                      bubble_EX_o,
    output logic                      flush_ID_o,
    output logic                      busy_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]               ld_stall_cnt_o,
    output logic [31:0]               flush_cnt_o
`endif
);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_stall_cycles
        $error("hazard_control_unit: LOAD_STALL_CYCLES must be in 1..7");
    end

    typedef enum logic {
        ST_IDLE,
        ST_LD_STALL
    } state_e;

    // Remaining stall cycles after the detection cycle.
    localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       hit;

    // Load in EX whose destination is read by ID; x0 is never a real producer.
    assign hit = valid_EX_i & is_load_EX_i & (rd_addr_EX_i != '0) &
                 ((rs1_used_ID_i & (rd_addr_EX_i == rs1_addr_ID_i)) |
                  (rs2_used_ID_i & (rd_addr_EX_i == rs2_addr_ID_i)));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_IF_o  = 1'b0;
        stall_ID_o  = 1'b0;
        stall_EX_o  = 1'b0;
        bubble_EX_o = 1'b0;
        flush_ID_o  = 1'b0;
        busy_o      = 1'b0;

        // While reset is asserted every output stays 0.
        if (!rst) begin
            busy_o = (state_q != ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    if (mdu_busy_i) begin
                        stall_IF_o = 1'b1;
                        stall_ID_o = 1'b1;
                        stall_EX_o = 1'b1;
                    end else if (branch_taken_EX_i) begin
                        // The ID instruction is squashed, so a coincident
                        // hit is irrelevant.
                        flush_ID_o  = 1'b1;
                        bubble_EX_o = 1'b1;
                    end else if (hit) begin
                        stall_IF_o  = 1'b1;
                        stall_ID_o  = 1'b1;
                        bubble_EX_o = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = ST_LD_STALL;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                ST_LD_STALL: begin
                    // The counter alone decides the end of the stall; hit is
                    // not looked at again.
                    stall_IF_o = 1'b1;
                    stall_ID_o = 1'b1;
                    if (mdu_busy_i) begin
                        // MDU freeze takes over EX; the load stall is paused.
                        stall_EX_o = 1'b1;
                    end else begin
                        bubble_EX_o = 1'b1;
                        if (cnt_q == 3'd1) begin
                            state_d = ST_IDLE;
                            cnt_d   = 3'd0;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before this edge, independent of order.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] ld_stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        ld_bubble;

    // A bubble without a flush can only come from a load hazard.
    assign ld_bubble = bubble_EX_o & ~flush_ID_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_stall_cnt_q <= 32'd0;
            flush_cnt_q    <= 32'd0;
        end else begin
            if (ld_bubble && (ld_stall_cnt_q != 32'hFFFF_FFFF)) begin
                ld_stall_cnt_q <= ld_stall_cnt_q + 32'd1;
            end
            if (flush_ID_o && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign ld_stall_cnt_o = ld_stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;
`endif

    // EX is a bubble during a load stall, so a taken branch there means the
    // surrounding pipeline is broken.
    a_no_branch_in_ld_stall : assert property (
        @(posedge clk) disable iff (rst)
        (state_q == ST_LD_STALL) |-> !branch_taken_EX_i
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// Bench for hazard_control_unit. Two instances share all inputs: one with a
// single-cycle load stall and one with a three-cycle load stall. Outputs are
// packed as {stall_IF, stall_ID, stall_EX, bubble_EX, flush_ID, busy}.
// The reference model tracks, per instance, only how many load-stall cycles
// are still owed after the current cycle.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [AW-1:0] rd;
        logic          valid;
        logic          load;
        logic          br;
        logic          mdu;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [5:0] e1;
        logic [5:0] e3;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    in_t  drv;

    always #5 clk = ~clk;

    logic s_if1, s_id1, s_ex1, bub1, fl1, busy1;
    logic s_if3, s_id3, s_ex3, bub3, fl3, busy3;
    logic [5:0] o1, o3;
    assign o1 = {s_if1, s_id1, s_ex1, bub1, fl1, busy1};
    assign o3 = {s_if3, s_id3, s_ex3, bub3, fl3, busy3};

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lsc1, fc1, lsc3, fc3;
`endif

    hazard_control_unit #(.REG_ADDR_WIDTH(AW), .LOAD_STALL_CYCLES(1)) dut1 (
        .clk               (clk),
        .rst               (rst),
        .rs1_addr_ID_i     (drv.rs1),
        .rs2_addr_ID_i     (drv.rs2),
        .rs1_used_ID_i     (drv.u1),
        .rs2_used_ID_i     (drv.u2),
        .rd_addr_EX_i      (drv.rd),
        .valid_EX_i        (drv.valid),
        .is_load_EX_i      (drv.load),
        .branch_taken_EX_i (drv.br),
        .mdu_busy_i        (drv.mdu),
        .stall_IF_o        (s_if1),
        .stall_ID_o        (s_id1),
        .stall_EX_o        (s_ex1),
        .bubble_EX_o       (bub1),
        .flush_ID_o        (fl1),
        .busy_o            (busy1)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .ld_stall_cnt_o    (lsc1),
        .flush_cnt_o       (fc1)
`endif
    );

    hazard_control_unit #(.REG_ADDR_WIDTH(AW), .LOAD_STALL_CYCLES(3)) dut3 (
        .clk               (clk),
        .rst               (rst),
        .rs1_addr_ID_i     (drv.rs1),
        .rs2_addr_ID_i     (drv.rs2),
        .rs1_used_ID_i     (drv.u1),
        .rs2_used_ID_i     (drv.u2),
        .rd_addr_EX_i      (drv.rd),
        .valid_EX_i        (drv.valid),
        .is_load_EX_i      (drv.load),
        .branch_taken_EX_i (drv.br),
        .mdu_busy_i        (drv.mdu),
        .stall_IF_o        (s_if3),
        .stall_ID_o        (s_id3),
        .stall_EX_o        (s_ex3),
        .bubble_EX_o       (bub3),
        .flush_ID_o        (fl3),
        .busy_o            (busy3)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .ld_stall_cnt_o    (lsc3),
        .flush_cnt_o       (fc3)
`endif
    );

    int checks = 0;
    int errors = 0;
    int rem1   = 0;   // load-stall cycles still owed after this cycle
    int rem3   = 0;
    int m_ls1  = 0, m_fl1 = 0, m_ls3 = 0, m_fl3 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t mk(input int rs1, input bit u1, input int rs2, input bit u2,
                               input int rd, input bit valid, input bit load,
                               input bit br, input bit mdu);
        in_t v;
        v.rs1   = AW'(rs1);
        v.u1    = u1;
        v.rs2   = AW'(rs2);
        v.u2    = u2;
        v.rd    = AW'(rd);
        v.valid = valid;
        v.load  = load;
        v.br    = br;
        v.mdu   = mdu;
        return v;
    endfunction

    function automatic bit is_hit(input in_t v);
        return v.valid && v.load && (v.rd != 0) &&
               ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
    endfunction

    function automatic logic [5:0] model_out(input int rem, input in_t v);
        if (rem > 0) return v.mdu ? 6'b111001 : 6'b110101;
        if (v.mdu)   return 6'b111000;
        if (v.br)    return 6'b000110;
        if (is_hit(v)) return 6'b110100;
        return 6'b000000;
    endfunction

    function automatic int model_next(input int rem, input int n, input in_t v);
        if (rem > 0) return v.mdu ? rem : rem - 1;
        if (!v.mdu && !v.br && is_hit(v)) return n - 1;
        return 0;
    endfunction

    // Called at posedge+1; drives one cycle, checks at negedge, advances model.
    task automatic step(input in_t v, input bit from_tbl, input logic [5:0] t1,
                        input logic [5:0] t3, input string tag);
        logic [5:0] m1, m3;
        drv = v;
        @(negedge clk);
        m1 = model_out(rem1, v);
        m3 = model_out(rem3, v);
        check({tag, " n1"}, {26'b0, o1}, {26'b0, (from_tbl ? t1 : m1)});
        check({tag, " n3"}, {26'b0, o3}, {26'b0, (from_tbl ? t3 : m3)});
        if (m1[2] && !m1[1]) m_ls1++;
        if (m1[1])           m_fl1++;
        if (m3[2] && !m3[1]) m_ls3++;
        if (m3[1])           m_fl3++;
        rem1 = model_next(rem1, 1, v);
        rem3 = model_next(rem3, 3, v);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[20];
    in_t  idle_in, hit_in;

    initial begin
        idle_in = '0;
        hit_in  = mk(0, 0, 7, 1, 7, 1, 1, 0, 0);

        tbl[0]  = '{idle_in,                          6'b000000, 6'b000000};
        tbl[1]  = '{mk(5, 1, 0, 0, 5, 1, 1, 0, 0),    6'b110100, 6'b110100};
        tbl[2]  = '{idle_in,                          6'b000000, 6'b110101};
        tbl[3]  = '{idle_in,                          6'b000000, 6'b110101};
        tbl[4]  = '{idle_in,                          6'b000000, 6'b000000};
        tbl[5]  = '{mk(0, 1, 0, 0, 0, 1, 1, 0, 0),    6'b000000, 6'b000000};
        tbl[6]  = '{mk(5, 0, 3, 1, 5, 1, 1, 0, 0),    6'b000000, 6'b000000};
        tbl[7]  = '{mk(0, 0, 7, 1, 7, 1, 1, 1, 0),    6'b000110, 6'b000110};
        tbl[8]  = '{mk(0, 0, 7, 1, 7, 0, 1, 0, 0),    6'b000000, 6'b000000};
        tbl[9]  = '{mk(0, 0, 7, 1, 7, 1, 1, 0, 1),    6'b111000, 6'b111000};
        tbl[10] = '{hit_in,                           6'b110100, 6'b110100};
        tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1),    6'b111000, 6'b111001};
        tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1),    6'b111000, 6'b111001};
        tbl[13] = '{idle_in,                          6'b000000, 6'b110101};
        tbl[14] = '{hit_in,                           6'b110100, 6'b110101};
        tbl[15] = '{hit_in,                           6'b110100, 6'b110100};
        tbl[16] = '{idle_in,                          6'b000000, 6'b110101};
        tbl[17] = '{idle_in,                          6'b000000, 6'b110101};
        tbl[18] = '{idle_in,                          6'b000000, 6'b000000};
        tbl[19] = '{mk(5, 1, 0, 0, 5, 1, 0, 0, 0),    6'b000000, 6'b000000};

        // Reset state, with a hazard present to show the outputs are forced low.
        drv = hit_in;
        rst = 1'b1;
        #2;
        check("reset n1", {26'b0, o1}, 32'd0);
        check("reset n3", {26'b0, o3}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].in, 1'b1, tbl[i].e1, tbl[i].e3, $sformatf("tbl[%0d]", i));
        end

        // Reset pulsed in the second cycle of a three-cycle stall.
        step(hit_in,  1'b1, 6'b110100, 6'b110100, "rstseq hit");
        step(idle_in, 1'b1, 6'b000000, 6'b110101, "rstseq c2");
        drv = hit_in;
        #2;
        rst = 1'b1;
        #1;
        check("rst mid n1", {26'b0, o1}, 32'd0);
        check("rst mid n3", {26'b0, o3}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("rst ldcnt n3", lsc3, 32'd0);
        check("rst flcnt n3", fc3, 32'd0);
`endif
        rem1 = 0; rem3 = 0;
        m_ls1 = 0; m_fl1 = 0; m_ls3 = 0; m_fl3 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(idle_in, 1'b1, 6'b000000, 6'b000000, "post rst");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_t v;
            v.rs1   = AW'($urandom_range(0, 3));
            v.rs2   = AW'($urandom_range(0, 3));
            v.rd    = AW'($urandom_range(0, 3));
            v.u1    = 1'($urandom_range(0, 1));
            v.u2    = 1'($urandom_range(0, 1));
            v.valid = ($urandom_range(0, 3) != 0);
            v.load  = ($urandom_range(0, 3) != 0);
            v.mdu   = ($urandom_range(0, 6) == 0);
            v.br    = (rem3 == 0) && ($urandom_range(0, 6) == 0);
            step(v, 1'b0, 6'b0, 6'b0, $sformatf("rnd[%0d]", i));
        end

`ifdef HAZARD_PERF_CNT_EN
        check("ldcnt n1", lsc1, 32'(m_ls1));
        check("flcnt n1", fc1,  32'(m_fl1));
        check("ldcnt n3", lsc3, 32'(m_ls3));
        check("flcnt n3", fc3,  32'(m_fl3));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
